// File: rtl/reg_file_writeback_stage.sv
// Write-back stage feeding the register file write port: result FIFO,
// registered write port and per-register pending-write scoreboard.
module reg_file_writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_WIDTH      = 4,
    parameter int unsigned NUM_REGS       = 2**SEL_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned PEND_CNT_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_valid,
    input  logic [SEL_WIDTH-1:0]            issue_sel,
    output logic                            issue_stall,
    input  logic [SEL_WIDTH-1:0]            query_sel_ra,
    input  logic [SEL_WIDTH-1:0]            query_sel_rb,
    input  logic [SEL_WIDTH-1:0]            query_sel_rc,
    output logic                            query_busy_ra,
    output logic                            query_busy_rb,
    output logic                            query_busy_rc,
    input  logic                            res_valid,
    output logic                            res_ready,
    input  logic [SEL_WIDTH-1:0]            res_sel,
    input  logic [DATA_WIDTH-1:0]           res_data,
    input  logic                            wb_hold,
    output logic                            rf_write_en,
    output logic [SEL_WIDTH-1:0]            rf_write_sel,
    output logic [DATA_WIDTH-1:0]           rf_write_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            err_underflow
);
    localparam int unsigned PTR_WIDTH   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PEND_CNT_WIDTH-1:0] PEND_MAX = '1;

    typedef struct packed {
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t                 fifo_mem [FIFO_DEPTH];
    wb_entry_t                 head_c;
    logic [PTR_WIDTH-1:0]      wr_ptr;
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic                      push_c;
    logic                      pop_c;
    logic                      issue_inc_c;
    logic                      underflow_c;
    logic [NUM_REGS-1:0]       inc_vec_c;
    logic [NUM_REGS-1:0]       dec_vec_c;
    logic [PEND_CNT_WIDTH-1:0] pend_cnt [NUM_REGS];

    // Handshake and pop decisions depend only on registered count
    always_comb begin
        res_ready = rst_n && (fifo_count < COUNT_WIDTH'(FIFO_DEPTH));
        push_c    = res_valid && res_ready;
        pop_c     = (fifo_count != '0) && !wb_hold;
        head_c    = fifo_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= '{sel: res_sel, data: res_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            fifo_count <= fifo_count + COUNT_WIDTH'(push_c) - COUNT_WIDTH'(pop_c);
        end
    end

    // Writes to the zero register are popped but never reach the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en   <= 1'b0;
            rf_write_sel  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write_en <= pop_c && (head_c.sel != '0);
            if (pop_c) begin
                rf_write_sel  <= head_c.sel;
                rf_write_data <= head_c.data;
            end
        end
    end

    // A retiring write frees a slot in the same cycle, so a saturated issue may proceed
    always_comb begin
        issue_stall = issue_valid && (issue_sel != '0) && (pend_cnt[issue_sel] == PEND_MAX)
                      && !(rf_write_en && (rf_write_sel == issue_sel));
        issue_inc_c = issue_valid && !issue_stall && (issue_sel != '0);
        underflow_c = rf_write_en && (pend_cnt[rf_write_sel] == '0);
        inc_vec_c   = '0;
        dec_vec_c   = '0;
        if (issue_inc_c) begin
            inc_vec_c[issue_sel] = 1'b1;
        end
        if (rf_write_en) begin
            dec_vec_c[rf_write_sel] = 1'b1;
        end
        query_busy_ra = (query_sel_ra != '0) && (pend_cnt[query_sel_ra] != '0);
        query_busy_rb = (query_sel_rb != '0) && (pend_cnt[query_sel_rb] != '0);
        query_busy_rc = (query_sel_rc != '0) && (pend_cnt[query_sel_rc] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_cnt[r] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec_c[r] && !dec_vec_c[r]) begin
                    pend_cnt[r] <= pend_cnt[r] + PEND_CNT_WIDTH'(1);
                end else if (dec_vec_c[r] && !inc_vec_c[r] && (pend_cnt[r] != '0)) begin
                    pend_cnt[r] <= pend_cnt[r] - PEND_CNT_WIDTH'(1);
                end
            end
            if (underflow_c) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_writeback_stage.sv
// Bench for reg_file_writeback_stage: directed scenarios plus randomized
// traffic checked every cycle against a queue/array reference model.
module tb_reg_file_writeback_stage;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NR = 16;
    localparam int FD = 2;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic [SW-1:0] issue_sel;
    logic          issue_stall;
    logic [SW-1:0] query_sel_ra, query_sel_rb, query_sel_rc;
    logic          query_busy_ra, query_busy_rb, query_busy_rc;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] res_sel;
    logic [DW-1:0] res_data;
    logic          wb_hold;
    logic          rf_write_en;
    logic [SW-1:0] rf_write_sel;
    logic [DW-1:0] rf_write_data;
    logic [1:0]    fifo_count;
    logic          err_underflow;

    always #5 clk = ~clk;

    reg_file_writeback_stage dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_stall(issue_stall),
        .query_sel_ra(query_sel_ra), .query_sel_rb(query_sel_rb), .query_sel_rc(query_sel_rc),
        .query_busy_ra(query_busy_ra), .query_busy_rb(query_busy_rb), .query_busy_rc(query_busy_rc),
        .res_valid(res_valid), .res_ready(res_ready), .res_sel(res_sel), .res_data(res_data),
        .wb_hold(wb_hold),
        .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
        .fifo_count(fifo_count), .err_underflow(err_underflow)
    );

    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_q[$];
    int            m_cnt [NR];
    bit            m_err;
    bit            m_en;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_err  = 1'b0;
        m_en   = 1'b0;
        m_sel  = '0;
        m_data = '0;
    endtask

    function automatic bit exp_busy(input logic [SW-1:0] q);
        return (q != 0) && (m_cnt[q] != 0);
    endfunction

    task automatic idle();
        issue_valid = 1'b0;
        issue_sel   = '0;
        res_valid   = 1'b0;
        res_sel     = '0;
        res_data    = '0;
        wb_hold     = 1'b0;
    endtask

    // One clock: compare all outputs with the model, then advance the model over the edge
    task automatic cycle();
        bit            e_ready, e_stall, push, pop, inc, n_en;
        logic [SW-1:0] n_sel;
        logic [DW-1:0] n_data;
        int            n_cnt [NR];
        ent_t          h;
        #1;
        e_ready = (m_q.size() < FD);
        e_stall = issue_valid && (issue_sel != 0) && (m_cnt[issue_sel] == PMAX)
                  && !(m_en && (m_sel == issue_sel));
        chk("res_ready", 64'(res_ready), 64'(e_ready));
        chk("issue_stall", 64'(issue_stall), 64'(e_stall));
        chk("busy_ra", 64'(query_busy_ra), 64'(exp_busy(query_sel_ra)));
        chk("busy_rb", 64'(query_busy_rb), 64'(exp_busy(query_sel_rb)));
        chk("busy_rc", 64'(query_busy_rc), 64'(exp_busy(query_sel_rc)));
        chk("rf_write_en", 64'(rf_write_en), 64'(m_en));
        chk("rf_write_sel", 64'(rf_write_sel), 64'(m_sel));
        chk("rf_write_data", 64'(rf_write_data), 64'(m_data));
        chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));

        push = res_valid && e_ready;
        pop  = (m_q.size() != 0) && !wb_hold;
        inc  = issue_valid && !e_stall && (issue_sel != 0);
        n_cnt = m_cnt;
        if (m_en && (m_cnt[m_sel] == 0)) m_err = 1'b1;
        if (inc) n_cnt[issue_sel]++;
        if (m_en && (n_cnt[m_sel] > 0)) n_cnt[m_sel]--;
        n_en   = 1'b0;
        n_sel  = m_sel;
        n_data = m_data;
        if (pop) begin
            h      = m_q.pop_front();
            n_en   = (h.sel != 0);
            n_sel  = h.sel;
            n_data = h.data;
        end
        if (push) m_q.push_back('{sel: res_sel, data: res_data});

        @(posedge clk);
        #1;
        m_cnt  = n_cnt;
        m_en   = n_en;
        m_sel  = n_sel;
        m_data = n_data;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_en"}, 64'(rf_write_en), 64'd0);
        chk({tag, "_sel"}, 64'(rf_write_sel), 64'd0);
        chk({tag, "_data"}, 64'(rf_write_data), 64'd0);
        chk({tag, "_count"}, 64'(fifo_count), 64'd0);
        chk({tag, "_ready"}, 64'(res_ready), 64'd0);
        chk({tag, "_err"}, 64'(err_underflow), 64'd0);
        chk({tag, "_busy"}, 64'({query_busy_ra, query_busy_rb, query_busy_rc}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        query_sel_ra = 4'd5;
        query_sel_rb = 4'd3;
        query_sel_rc = 4'd7;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("init_rst");
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 64'(res_ready), 64'd1);

        // Issue r5, then its result: write appears two edges after the push
        issue_valid = 1'b1; issue_sel = 4'd5;
        cycle();
        idle();
        res_valid = 1'b1; res_sel = 4'd5; res_data = 32'hDEAD_BEEF;
        #1;
        chk("t2_busy_r5", 64'(query_busy_ra), 64'd1);
        cycle();
        idle();
        chk("t2_count", 64'(fifo_count), 64'd1);
        chk("t2_en_not_yet", 64'(rf_write_en), 64'd0);
        cycle();
        chk("t2_en", 64'(rf_write_en), 64'd1);
        chk("t2_sel", 64'(rf_write_sel), 64'd5);
        chk("t2_data", 64'(rf_write_data), 64'hDEAD_BEEF);
        chk("t2_busy_during_write", 64'(query_busy_ra), 64'd1);
        cycle();
        chk("t2_busy_after", 64'(query_busy_ra), 64'd0);
        chk("t2_en_after", 64'(rf_write_en), 64'd0);

        // Hold the write port, fill the FIFO, then drain in order
        wb_hold = 1'b1;
        issue_valid = 1'b1; issue_sel = 4'd1;
        res_valid = 1'b1; res_sel = 4'd1; res_data = 32'h111;
        cycle();
        issue_sel = 4'd2; res_sel = 4'd2; res_data = 32'h222;
        cycle();
        issue_valid = 1'b0; res_sel = 4'd9; res_data = 32'h999;
        #1;
        chk("t3_ready_full", 64'(res_ready), 64'd0);
        chk("t3_count_full", 64'(fifo_count), 64'd2);
        cycle();
        idle();
        cycle();
        chk("t3_w1_en", 64'(rf_write_en), 64'd1);
        chk("t3_w1_sel", 64'(rf_write_sel), 64'd1);
        chk("t3_w1_data", 64'(rf_write_data), 64'h111);
        cycle();
        chk("t3_w2_en", 64'(rf_write_en), 64'd1);
        chk("t3_w2_sel", 64'(rf_write_sel), 64'd2);
        chk("t3_w2_data", 64'(rf_write_data), 64'h222);
        chk("t3_ready_again", 64'(res_ready), 64'd1);
        cycle();

        // Saturate r3, then issue again in the cycle an r3 write retires
        issue_valid = 1'b1; issue_sel = 4'd3;
        repeat (3) cycle();
        res_valid = 1'b1; res_sel = 4'd3; res_data = 32'h33;
        #1;
        chk("t4_stall_sat", 64'(issue_stall), 64'd1);
        chk("t4_busy_r3", 64'(query_busy_rb), 64'd1);
        cycle();
        idle();
        cycle();
        chk("t4_write_r3", 64'(rf_write_en && rf_write_sel == 4'd3), 64'd1);
        issue_valid = 1'b1; issue_sel = 4'd3;
        #1;
        chk("t4_stall_retire", 64'(issue_stall), 64'd0);
        cycle();
        #1;
        chk("t4_stall_still_sat", 64'(issue_stall), 64'd1);
        idle();
        cycle();

        // Zero-register result and issue
        res_valid = 1'b1; res_sel = 4'd0; res_data = 32'h1;
        cycle();
        idle();
        cycle();
        chk("t5_en_zero", 64'(rf_write_en), 64'd0);
        issue_valid = 1'b1; issue_sel = 4'd0; query_sel_ra = 4'd0;
        #1;
        chk("t5_stall_r0", 64'(issue_stall), 64'd0);
        chk("t5_busy_r0", 64'(query_busy_ra), 64'd0);
        cycle();
        idle();

        // Unissued write: underflow flag, counter stays 0
        chk("t6_err_before", 64'(err_underflow), 64'd0);
        res_valid = 1'b1; res_sel = 4'd7; res_data = 32'h77;
        cycle();
        idle();
        cycle();
        chk("t6_write_r7", 64'(rf_write_en && rf_write_sel == 4'd7), 64'd1);
        cycle();
        chk("t6_err_set", 64'(err_underflow), 64'd1);
        chk("t6_busy_r7", 64'(query_busy_rc), 64'd0);
        repeat (3) cycle();
        chk("t6_err_sticky", 64'(err_underflow), 64'd1);

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            issue_valid  = 1'($urandom_range(0, 1));
            issue_sel    = 4'($urandom_range(0, 7));
            res_valid    = 1'($urandom_range(0, 1));
            res_sel      = 4'($urandom_range(0, 7));
            res_data     = $urandom;
            wb_hold      = ($urandom_range(0, 3) == 0);
            query_sel_ra = 4'($urandom_range(0, 7));
            query_sel_rb = 4'($urandom_range(0, 7));
            query_sel_rc = 4'($urandom_range(0, 15));
            if (i == 300) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_state("mid_rst");
                model_reset();
                @(posedge clk);
                #1;
                check_reset_state("mid_rst_hold");
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
